// File: rtl/mult_pkg.sv
// Shared arithmetic building blocks for the multiplier family: bit-level adder
// cells, prefix-network cells and the Baugh-Wooley constant.
package mult_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Cell outputs are packed as {carry, sum}.
  function automatic logic [1:0] ha(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // A grey cell only makes a generate: its span already reaches bit 0.
  function automatic logic grey(input logic g_hi, input logic p_hi, input logic g_lo);
    return g_hi | (p_hi & g_lo);
  endfunction

  function automatic gp_t black(input logic g_hi, input logic p_hi,
                                input logic g_lo, input logic p_lo);
    gp_t r;
    r.g = g_hi | (p_hi & g_lo);
    r.p = p_hi & p_lo;
    return r;
  endfunction

  function automatic int prefix_levels(input int n);
    return $clog2(n);
  endfunction

  // Constant 1s at columns W and 2W-1 that complete the signed product.
  function automatic logic [63:0] bw_correction(input int width);
    logic [63:0] c;
    c = '0;
    c[width] = 1'b1;
    c[2*width-1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/prefix_adder_n.sv
// Combinational Sklansky parallel-prefix adder: sum = a + b mod 2^N,
// carry-in 0, carry-out discarded.
module prefix_adder_n
  import mult_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  localparam int L = prefix_levels(N);

  for (genvar gl = 0; gl <= L; gl++) begin : g_lvl
    logic [N-1:0] g;
    logic [N-1:0] p;
    if (gl == 0) begin : g_init
      assign g = a & b;
      assign p = a ^ b;
    end else begin : g_tree
      for (genvar gi = 0; gi < N; gi++) begin : g_bit
        localparam int SPAN = 1 << (gl - 1);
        // Last bit of the lower half of this 2*SPAN block.
        localparam int J = (gi / SPAN) * SPAN - 1;
        if (((gi / SPAN) % 2) == 0) begin : g_pass
          assign g[gi] = g_lvl[gl-1].g[gi];
          assign p[gi] = g_lvl[gl-1].p[gi];
        end else if (J < SPAN) begin : g_grey
          assign g[gi] = grey(g_lvl[gl-1].g[gi], g_lvl[gl-1].p[gi], g_lvl[gl-1].g[J]);
          assign p[gi] = 1'b0;
        end else begin : g_black
          gp_t gp;
          assign gp = black(g_lvl[gl-1].g[gi], g_lvl[gl-1].p[gi],
                            g_lvl[gl-1].g[J], g_lvl[gl-1].p[J]);
          assign g[gi] = gp.g;
          assign p[gi] = gp.p;
        end
      end
    end
  end

  assign sum[0] = g_lvl[0].p[0];
  for (genvar gi = 1; gi < N; gi++) begin : g_sum
    assign sum[gi] = g_lvl[0].p[gi] ^ g_lvl[L].g[gi-1];
  end

endmodule

// File: rtl/pipelined_mult_tree.sv
// Two-stage WIDTH x WIDTH multiplier (signed or unsigned per beat): stage 1 is
// Baugh-Wooley partial products plus carry-save reduction, stage 2 a prefix add.
module pipelined_mult_tree
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;
  localparam logic [63:0] BW_FULL = bw_correction(WIDTH);
  localparam logic [PW-1:0] BW_CONST = BW_FULL[PW-1:0];

  logic [PW-1:0] pp_row [WIDTH+1];

  // Signed beats invert the cross terms with the sign bits; the sign*sign
  // term keeps its true polarity.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] bits;
    if (gi == WIDTH - 1) begin : g_msb_row
      assign flip = {1'b0, {(WIDTH-1){in_signed}}};
    end else begin : g_row
      assign flip = {in_signed, {(WIDTH-1){1'b0}}};
    end
    assign bits = (in_x & {WIDTH{in_y[gi]}}) ^ flip;
    assign pp_row[gi] = {{WIDTH{1'b0}}, bits} << gi;
  end
  assign pp_row[WIDTH] = in_signed ? BW_CONST : '0;

  // Each step folds one more row into a sum/carry pair with a row of FA cells.
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_csa
    logic [PW-1:0] a_in;
    logic [PW-1:0] b_in;
    logic [PW-1:0] sum_bits;
    logic [PW-1:0] carry_bits;
    if (gi == 0) begin : g_first
      assign a_in = pp_row[0];
      assign b_in = pp_row[1];
    end else begin : g_next
      assign a_in = g_csa[gi-1].sum_bits;
      assign b_in = g_csa[gi-1].carry_bits;
    end
    assign carry_bits[0] = 1'b0;
    for (genvar gj = 0; gj < PW; gj++) begin : g_col
      if (gj < PW - 1) begin : g_fa
        assign {carry_bits[gj+1], sum_bits[gj]} = fa(a_in[gj], b_in[gj], pp_row[gi+2][gj]);
      end else begin : g_top
        assign sum_bits[gj] = a_in[gj] ^ b_in[gj] ^ pp_row[gi+2][gj];
      end
    end
  end

  logic             v1_reg;
  logic             v2_reg;
  logic [PW-1:0]    row_s_reg;
  logic [PW-1:0]    row_c_reg;
  logic [TAG_W-1:0] tag1_reg;
  logic [PW-1:0]    out_p_reg;
  logic [TAG_W-1:0] out_tag_reg;
  logic [PW-1:0]    sum_p;
  logic             adv1;
  logic             adv2;

  prefix_adder_n #(.N(PW)) u_cpa (
    .a   (row_s_reg),
    .b   (row_c_reg),
    .sum (sum_p)
  );

  // in_ready depends combinationally on out_ready through adv2/adv1.
  assign adv2     = !v2_reg || out_ready;
  assign adv1     = !v1_reg || adv2;
  assign in_ready = adv1 && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      out_p_reg   <= '0;
      out_tag_reg <= '0;
    end else begin
      if (adv1) begin
        v1_reg <= in_valid;
      end
      if (in_valid && in_ready) begin
        row_s_reg <= g_csa[WIDTH-2].sum_bits;
        row_c_reg <= g_csa[WIDTH-2].carry_bits;
        tag1_reg  <= in_tag;
      end
      if (adv2) begin
        v2_reg <= v1_reg;
        if (v1_reg) begin
          out_p_reg   <= sum_p;
          out_tag_reg <= tag1_reg;
        end
      end
    end
  end

  assign out_valid = v2_reg;
  assign out_p     = out_p_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_pipelined_mult_tree.sv
// Directed checks on a WIDTH=8 instance plus scoreboard sweeps at WIDTH=4
// (exhaustive), 8 and 13 with random handshake timing.
module tb_pipelined_mult_tree;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                          input int w, input logic sg);
    logic [63:0] mask;
    logic [63:0] xe;
    logic [63:0] ye;
    mask = (64'd1 << w) - 64'd1;
    xe = x & mask;
    ye = y & mask;
    if (sg) begin
      if (xe[w-1]) xe = xe | ~mask;
      if (ye[w-1]) ye = ye | ~mask;
    end
    return (xe * ye) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Directed instance
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic        in_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic [3:0]  out_tag;

  pipelined_mult_tree #(.WIDTH(8), .TAG_W(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  // Sweep instances
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int W  = (gi == 0) ? 4 : ((gi == 1) ? 8 : 13);
    localparam int NB = (gi == 0) ? 512 : 300;
    logic           s_rst;
    logic           s_in_valid;
    logic           s_in_ready;
    logic           s_in_signed;
    logic           s_out_valid;
    logic           s_out_ready;
    logic           done;
    logic [W-1:0]   s_x;
    logic [W-1:0]   s_y;
    logic [9:0]     s_tag;
    logic [9:0]     s_out_tag;
    logic [2*W-1:0] s_out_p;

    pipelined_mult_tree #(.WIDTH(W), .TAG_W(10)) u_sw (
      .clk       (clk),
      .rst       (s_rst),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_x      (s_x),
      .in_y      (s_y),
      .in_signed (s_in_signed),
      .in_tag    (s_tag),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_p     (s_out_p),
      .out_tag   (s_out_tag)
    );

    initial begin
      logic [63:0] exp_q [$];
      logic [9:0]  tag_q [$];
      logic [63:0] e;
      logic [9:0]  t;
      int sent;
      int got;
      int cyc;
      sent = 0;
      got = 0;
      cyc = 0;
      done = 1'b0;
      s_rst = 1'b1;
      s_in_valid = 1'b0;
      s_x = '0;
      s_y = '0;
      s_in_signed = 1'b0;
      s_tag = '0;
      s_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      s_rst = 1'b0;
      while (got < NB && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        s_out_ready = ($urandom_range(0, 3) != 0);
        if (sent < NB) begin
          s_in_valid = ($urandom_range(0, 4) != 0);
          if (gi == 0) begin
            s_x = W'(sent);
            s_y = W'(sent >> W);
            s_in_signed = 1'(sent >> (2 * W));
          end else begin
            s_x = W'($urandom);
            s_y = W'($urandom);
            s_in_signed = 1'($urandom);
          end
          s_tag = 10'(sent);
        end else begin
          s_in_valid = 1'b0;
        end
        #1;
        if (s_out_valid && s_out_ready) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("w%0d_spurious", W), 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk($sformatf("w%0d_p_tag%0d", W, t), 64'(s_out_p), e);
            chk($sformatf("w%0d_tag", W), 64'(s_out_tag), 64'(t));
          end
          got++;
        end
        if (s_in_valid && s_in_ready) begin
          exp_q.push_back(ref_mul(64'(s_x), 64'(s_y), W, s_in_signed));
          tag_q.push_back(s_tag);
          sent++;
        end
      end
      chk($sformatf("w%0d_result_count", W), 64'(got), 64'(NB));
      $display("sweep W=%0d: %0d results checked in %0d cycles", W, got, cyc);
      done = 1'b1;
    end
  end

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        sg;
    logic [3:0]  tag;
    logic [15:0] p;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [63:0] exp_q [$];
    logic [3:0]  etag_q [$];
    logic [63:0] e;
    logic [3:0]  t;
    logic        hold_v;
    logic [15:0] hold_p;
    logic [3:0]  hold_t;
    logic        saw_stall;
    int sent;
    int got;
    int k;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 4'd3,  16'hFE01};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 4'd5,  16'h4000};
    vecs[2]  = '{8'hFF, 8'h7F, 1'b1, 4'd6,  16'hFF81};
    vecs[3]  = '{8'hFF, 8'h7F, 1'b0, 4'd7,  16'h7E81};
    vecs[4]  = '{8'h00, 8'h37, 1'b1, 4'd8,  16'h0000};
    vecs[5]  = '{8'h7F, 8'h7F, 1'b1, 4'd9,  16'h3F01};
    vecs[6]  = '{8'h80, 8'h7F, 1'b1, 4'd10, 16'hC080};
    vecs[7]  = '{8'h80, 8'h01, 1'b1, 4'd11, 16'hFF80};
    vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 4'd12, 16'h0001};
    vecs[9]  = '{8'h12, 8'h34, 1'b0, 4'd13, 16'h03A8};
    vecs[10] = '{8'h80, 8'h80, 1'b0, 4'd14, 16'h4000};

    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_signed = 1'b0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_p", 64'(out_p), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;

    // Single isolated beats: latency 2, one-cycle valid pulse.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x = vecs[i].x;
      in_y = vecs[i].y;
      in_signed = vecs[i].sg;
      in_tag = vecs[i].tag;
      out_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_lat1_valid", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_p", i), 64'(out_p), 64'(vecs[i].p));
      chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(vecs[i].tag));
      $display("vec %0d: x=%02h y=%02h signed=%0d -> p=%04h tag=%0d", i,
               vecs[i].x, vecs[i].y, vecs[i].sg, out_p, out_tag);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_pulse_end", i), 64'(out_valid), 64'd0);
    end

    // Back-to-back stream with mixed signed/unsigned beats.
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (c < 16) begin
        in_valid = 1'b1;
        in_x = 8'(c * 17 + 1);
        in_y = 8'(c * 7 + 3);
        in_signed = c[0];
        in_tag = 4'(c);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 16) chk($sformatf("tp%0d_in_ready", c), 64'(in_ready), 64'd1);
      chk($sformatf("tp%0d_out_valid", c), 64'(out_valid), 64'(c >= 2 && c < 18));
      if (c >= 2 && c < 18) begin
        k = c - 2;
        chk($sformatf("tp%0d_tag", c), 64'(out_tag), 64'(k));
        chk($sformatf("tp%0d_p", c), 64'(out_p), ref_mul(64'(k * 17 + 1), 64'(k * 7 + 3), 8, k[0]));
        $display("tp cycle %0d: p=%04h tag=%0d", c, out_p, out_tag);
      end
    end

    // Backpressure: out_ready low for 3 cycles while streaming.
    sent = 0;
    got = 0;
    hold_v = 1'b0;
    hold_p = '0;
    hold_t = '0;
    saw_stall = 1'b0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c < 7);
      if (sent < 10) begin
        in_valid = 1'b1;
        in_x = 8'(sent * 13 + 5);
        in_y = 8'(255 - sent * 9);
        in_signed = sent[1];
        in_tag = 4'(sent + 6);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (hold_v) begin
        chk($sformatf("bp%0d_hold_valid", c), 64'(out_valid), 64'd1);
        chk($sformatf("bp%0d_hold_p", c), 64'(out_p), 64'(hold_p));
        chk($sformatf("bp%0d_hold_tag", c), 64'(out_tag), 64'(hold_t));
      end
      if (!out_ready && out_valid && !in_ready) saw_stall = 1'b1;
      hold_v = out_valid && !out_ready;
      hold_p = out_p;
      hold_t = out_tag;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_spurious", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          t = etag_q.pop_front();
          chk($sformatf("bp_p_tag%0d", t), 64'(out_p), e);
          chk("bp_tag", 64'(out_tag), 64'(t));
          $display("bp cycle %0d: p=%04h tag=%0d", c, out_p, out_tag);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(64'(in_x), 64'(in_y), 8, in_signed));
        etag_q.push_back(in_tag);
        sent++;
      end
    end
    chk("bp_in_ready_low_when_full", 64'(saw_stall), 64'd1);
    chk("bp_result_count", 64'(got), 64'd10);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_no_duplicate", 64'(out_valid), 64'd0);

    // Reset with both stages full.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_x = 8'h11;
    in_y = 8'h22;
    in_signed = 1'b0;
    in_tag = 4'd1;
    @(negedge clk);
    in_x = 8'h33;
    in_tag = 4'd2;
    #1;
    chk("rs_fill_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #1;
    chk("rs_full_valid", 64'(out_valid), 64'd1);
    chk("rs_full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("rs_in_ready_during_rst", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_out_p", 64'(out_p), 64'd0);
    chk("rs_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    #1;
    chk("rs_no_stale_beat", 64'(out_valid), 64'd0);
    in_valid = 1'b1;
    in_x = 8'h9C;
    in_y = 8'h05;
    in_signed = 1'b0;
    in_tag = 4'd9;
    #1;
    chk("rs_post_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rs_post_lat1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("rs_post_valid", 64'(out_valid), 64'd1);
    chk("rs_post_p", 64'(out_p), 64'h030C);
    chk("rs_post_tag", 64'(out_tag), 64'd9);
    $display("post-reset beat: p=%04h tag=%0d", out_p, out_tag);

    for (int c = 0; c < 40000 && !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); c++) begin
      @(negedge clk);
    end
    chk("sweeps_finished", 64'({g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_mult_tree.md
Name: pipelined_mult_tree

Overview:
- Parametrised successor to the fixed-width combinational partial-product multiplier.
- Multiplies two WIDTH-bit operands, signed or unsigned per transaction, and produces the full 2*WIDTH-bit product.
- Two registered stages: stage 1 is partial-product generation plus the carry-save compression tree; stage 2 is the final parallel-prefix carry-propagate add.
- Valid/ready handshake on both sides with full backpressure; sits between operand producers and accumulator/datapath consumers.

Parameters:
- WIDTH, 8, operand width in bits (legal 4..32).
- TAG_W, 4, width of the opaque sideband tag carried with each transaction (legal 1..16).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat this cycle.
- in_x  input  WIDTH  multiplicand.
- in_y  input  WIDTH  multiplier.
- in_signed  input  1  1 = both operands two's complement; 0 = both unsigned.
- in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result beat.
- out_p  output  2*WIDTH  product.
- out_tag  output  TAG_W  tag of this product.

Behaviour:
- Reset (rst=1 at a clock edge): stage valid bits v1 and v2 clear, so out_valid=0. out_p and out_tag are forced to 0. in_ready is 0 while rst is high. Data registers other than the output need no reset.
- Transfer rules: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Stage 2 advance: adv2 = !v2 || out_ready.
- Stage 1 advance: adv1 = !v1 || adv2.
- in_ready = adv1 && !rst. This is a combinational path from out_ready; it is acceptable and must be documented at integration.
- Latency: an accepted beat appears on out_* exactly 2 cycles later if there is no stall. Sustained throughput is 1 beat per cycle when out_ready is held high.
- Stall behaviour: a stage whose advance is 0 holds its data and valid bit. No beat is dropped or duplicated. Holding a full pipe needs at most 2 beats of buffering, with no skid buffer beyond the two stages.
- Bubbles: a bubble (v1=0) flows into stage 2 when adv2=1, clearing v2 once the current output is consumed.
- Arithmetic, unsigned: out_p = in_x * in_y, exact in 2*WIDTH bits.
- Arithmetic, signed: out_p = two's-complement exact product in 2*WIDTH bits, including (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), which is positive and representable. Use a Baugh-Wooley style correction: complemented MSB-row terms plus constant 1s at columns W and 2W-1. No behavioural '*' operator in synthesised RTL.
- Tree: AND partial products, reduced with HA/FA cells (same cell definitions as the existing multipliers) to two rows. The two rows are registered at the end of stage 1, together with the tag.
- Final add: 2*WIDTH-bit parallel-prefix adder using grey/black cells, carry-in 0, carry-out discarded. Registered into out_p at the end of stage 2.
- in_signed is sampled with the operands and applies only to that beat. Mixed signed/unsigned beats back-to-back must each be correct.
- Reset mid-operation: in-flight beats are discarded. The first post-reset result is the first beat accepted after rst deasserts.
- Inputs with in_valid=0 are don't-care and must not alter state.

Decomposition:
- Shared package mult_pkg:
  - HA and FA cell modules, GREY and BLACK prefix cells.
  - Localparam function for the prefix level count, clog2(2*WIDTH).
  - A constant for the Baugh-Wooley correction pattern as a function of WIDTH.
- One natural sub-module: prefix_adder_n (parameter N). It is a purely combinational Sklansky-style a+b adder, reusable by other datapaths.
- Tree generation stays in the top module as generate loops over columns.

Test Plan:
- Unsigned, WIDTH=8: x=0xFF, y=0xFF, signed=0, tag=3 -> 2 cycles later out_p=0xFE01, out_tag=3, out_valid pulses 1 cycle with out_ready=1.
- Signed corner, WIDTH=8: x=0x80, y=0x80, signed=1 -> out_p=0x4000. Then x=0xFF, y=0x7F, signed=1 -> out_p=0xFF81. The same bits with signed=0 -> out_p=0x7E81.
- Throughput: 16 back-to-back beats, out_ready=1 -> 16 results on 16 consecutive cycles starting cycle 2, tags 0..15 in order, in_ready stays 1.
- Backpressure: stream beats, drop out_ready for 3 cycles -> in_ready=0 after the pipe fills (2 beats held). out_p/out_tag stay stable while out_valid=1 && !out_ready. No loss or duplication after release.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> next cycle out_valid=0, out_p=0, in_ready=0 during rst. A beat accepted after reset emerges with correct value 2 cycles later.
- Randomised sweep at WIDTH=4, 8, 13: random operands, mode, and out_ready -> every out_p matches a scoreboard product (exhaustive at WIDTH=4, all 512 combinations of x, y and mode).
